// File: rtl/switch_led_bank.sv
// Switch-to-LED bank: per-channel synchroniser and debouncer, press detection,
// toggle/latch state and a shared blink generator, mapped to LEDs by mode.
module switch_led_bank #(
  parameter int NUM_CH            = 4,
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int BLINK_HALF_CYCLES = 6250000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic [1:0]        i_Mode,
  input  logic              i_Clear,
  output logic [NUM_CH-1:0] o_LED,
  output logic [NUM_CH-1:0] o_Debounced,
  output logic [NUM_CH-1:0] o_Press
);

  localparam int CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BlinkW = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam logic [CntW-1:0]   CntMax   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_HALF_CYCLES - 1);

  typedef enum logic [1:0] {
    ModeFollow = 2'b00,
    ModeToggle = 2'b01,
    ModeBlink  = 2'b10,
    ModeLatch  = 2'b11
  } mode_e;

  logic [NUM_CH-1:0] sync1_q, sync2_q;
  logic [NUM_CH-1:0] stable_q, stable_d;
  logic [NUM_CH-1:0] press_q, press_d;
  logic [NUM_CH-1:0] toggle_q, toggle_d;
  logic [NUM_CH-1:0] latch_q, latch_d;
  logic [CntW-1:0]   count_q [NUM_CH];
  logic [CntW-1:0]   count_d [NUM_CH];
  logic [BlinkW-1:0] blinkCnt_q, blinkCnt_d;
  logic              phase_q, phase_d;

  // Any mismatch shorter than the debounce window drops the count back to 0.
  always_comb begin
    stable_d = stable_q;
    press_d  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      count_d[c] = '0;
      if (sync2_q[c] != stable_q[c]) begin
        if (count_q[c] == CntMax) begin
          stable_d[c] = sync2_q[c];
          press_d[c]  = sync2_q[c];
        end else begin
          count_d[c] = count_q[c] + 1'b1;
        end
      end
    end
    toggle_d = i_Clear ? '0 : (toggle_q ^ press_d);
    latch_d  = i_Clear ? '0 : (latch_q | press_d);
  end

  always_comb begin
    blinkCnt_d = blinkCnt_q + 1'b1;
    phase_d    = phase_q;
    if (blinkCnt_q == BlinkMax) begin
      blinkCnt_d = '0;
      phase_d    = ~phase_q;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      press_q    <= '0;
      toggle_q   <= '0;
      latch_q    <= '0;
      blinkCnt_q <= '0;
      phase_q    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) count_q[c] <= '0;
    end else begin
      sync1_q    <= i_Switch;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      press_q    <= press_d;
      toggle_q   <= toggle_d;
      latch_q    <= latch_d;
      blinkCnt_q <= blinkCnt_d;
      phase_q    <= phase_d;
      for (int c = 0; c < NUM_CH; c++) count_q[c] <= count_d[c];
    end
  end

  always_comb begin
    o_LED = stable_q;
    case (mode_e'(i_Mode))
      ModeFollow: o_LED = stable_q;
      ModeToggle: o_LED = toggle_q;
      ModeBlink:  o_LED = stable_q & {NUM_CH{phase_q}};
      ModeLatch:  o_LED = latch_q;
      default:    o_LED = stable_q;
    endcase
  end

  assign o_Debounced = stable_q;
  assign o_Press     = press_q;

endmodule

// File: tb/tb_switch_led_bank.sv
// Directed self-checking bench for switch_led_bank with short debounce and
// blink periods (NUM_CH=4, DEBOUNCE_CYCLES=4, BLINK_HALF_CYCLES=3).
module tb_switch_led_bank;

  logic       clock;
  logic       rstN;
  logic [3:0] sw;
  logic [1:0] mode;
  logic       clear;
  logic [3:0] led;
  logic [3:0] deb;
  logic [3:0] press;

  int testsRun    = 0;
  int testsFailed = 0;
  int pulseCount2 = 0;

  switch_led_bank #(
    .NUM_CH(4),
    .DEBOUNCE_CYCLES(4),
    .BLINK_HALF_CYCLES(3)
  ) dut (
    .i_Clk(clock),
    .i_Rst_L(rstN),
    .i_Switch(sw),
    .i_Mode(mode),
    .i_Clear(clear),
    .o_LED(led),
    .o_Debounced(deb),
    .o_Press(press)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Independent tally of channel-2 press pulses since the last reset.
  always @(negedge clock) begin
    if (!rstN) pulseCount2 = 0;
    else if (press[2]) pulseCount2++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] s, input logic [1:0] m,
                               input logic c);
    sw    = s;
    mode  = m;
    clear = c;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Leaves the bench 1 time unit after edge 0; the next posedge is edge 1.
  task automatic applyReset(input logic [3:0] s, input logic [1:0] m);
    rstN = 1'b0;
    applyStimulus(s, m, 1'b0);
    tick(2);
    rstN = 1'b1;
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(4'b1111, 2'b00, 1'b0);

    // Reset holds all outputs low in every mode even with switches pressed.
    for (int m = 0; m < 4; m++) begin
      mode = m[1:0];
      #1;
      checkOutput($sformatf("resetLed_m%0d", m), led, 4'b0000);
    end
    checkOutput("resetDeb", deb, 4'b0000);
    checkOutput("resetPress", press, 4'b0000);

    mode = 2'b00;
    tick(2);
    rstN = 1'b1;
    tick(5);
    checkOutput("relDebEdge5", deb, 4'b0000);
    tick(1);
    checkOutput("relDebEdge6", deb, 4'b1111);
    checkOutput("relPressEdge6", press, 4'b1111);
    tick(1);
    checkOutput("relPressEdge7", press, 4'b0000);
    checkOutput("relLedFollow", led, 4'b1111);

    // Bounce on channel 0 never reaches the debounce threshold.
    applyReset(4'b0000, 2'b00);
    for (int i = 0; i < 10; i++) begin
      sw = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      tick(2);
      checkOutput($sformatf("bounceDeb_%0d", i), deb, 4'b0000);
    end
    sw = 4'b0001;
    tick(5);
    checkOutput("holdLedEdge5", led, 4'b0000);
    tick(1);
    checkOutput("holdLedEdge6", led, 4'b0001);
    checkOutput("holdPressEdge6", press, 4'b0001);

    // Toggle mode: three presses on channel 2.
    applyReset(4'b0000, 2'b01);
    for (int p = 0; p < 3; p++) begin
      sw = 4'b0100;
      tick(6);
      checkOutput($sformatf("togPress_%0d", p), press, 4'b0100);
      checkOutput($sformatf("togLed_%0d", p), led, (p == 1) ? 4'b0000 : 4'b0100);
      tick(4);
      sw = 4'b0000;
      tick(6);
      checkOutput($sformatf("togRelDeb_%0d", p), deb, 4'b0000);
      checkOutput($sformatf("togRelPress_%0d", p), press, 4'b0000);
      tick(4);
    end
    checkOutput("togPulseCount", pulseCount2, 3);
    checkOutput("togLedFinal", led, 4'b0100);

    // Blink mode: phase is 1 during edges 3-5, 9-11, ... after reset release.
    applyReset(4'b0010, 2'b10);
    tick(6);
    for (int k = 6; k < 18; k++) begin
      checkOutput($sformatf("blinkLed_e%0d", k), led,
                  (((k / 3) % 2) == 1) ? 4'b0010 : 4'b0000);
      tick(1);
    end
    sw = 4'b0000;
    tick(5);
    checkOutput("blinkRelDeb5", deb, 4'b0010);
    tick(1);
    checkOutput("blinkRelDeb6", deb, 4'b0000);
    checkOutput("blinkRelLed", led, 4'b0000);

    // Latch mode with clear colliding with a fresh press.
    applyReset(4'b1001, 2'b11);
    tick(6);
    checkOutput("latchLedSet", led, 4'b1001);
    sw = 4'b0000;
    tick(10);
    checkOutput("latchLedHeld", led, 4'b1001);
    checkOutput("latchDebRel", deb, 4'b0000);
    sw = 4'b0001;
    tick(5);
    clear = 1'b1;
    tick(1);
    checkOutput("clearLed", led, 4'b0000);
    checkOutput("clearPress", press, 4'b0001);
    clear = 1'b0;
    tick(1);
    checkOutput("clearLedAfter", led, 4'b0000);
    mode = 2'b00;
    #1;
    checkOutput("clearFollowLed", led, 4'b0001);

    // Mode switches keep state; reset mid-debounce clears everything.
    applyReset(4'b0010, 2'b01);
    tick(6);
    checkOutput("modeTogLed", led, 4'b0010);
    sw = 4'b0000;
    tick(6);
    mode = 2'b00;
    #1;
    checkOutput("modeFollowLed", led, 4'b0000);
    mode = 2'b01;
    #1;
    checkOutput("modeBackTogLed", led, 4'b0010);
    sw = 4'b1000;
    tick(4);
    rstN = 1'b0;
    #1;
    checkOutput("midRstLed", led, 4'b0000);
    checkOutput("midRstDeb", deb, 4'b0000);
    checkOutput("midRstPress", press, 4'b0000);
    tick(2);
    rstN = 1'b1;
    tick(5);
    checkOutput("postRstDeb5", deb, 4'b0000);
    tick(1);
    checkOutput("postRstDeb6", deb, 4'b1000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
